// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared types, constants and helpers for the programmable clock divider
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  localparam int MIN_DIV = 2;

  // A divisor below MIN_DIV cannot form a period with both a high and a low phase
  function automatic logic legal_div(input logic [31:0] value);
    return value >= 32'(MIN_DIV);
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// rtl/clk_div_core.sv - period counter and phase generator for the divided clock
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             clk_out,
  output logic             clk_rise,
  output logic             boundary
);

  // en is the "active in the next cycle" request; the registers below describe
  // the output cycle that follows the edge, so clk_out never depends on inputs
  // combinationally.
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             active_q;
  logic             clk_out_q, clk_out_d;
  logic             clk_rise_q, clk_rise_d;

  // Last cycle of the current period; only meaningful while a period is active
  assign boundary = active_q && (cnt_q == (div - DIV_W'(1)));

  // Advance within the period, restart at the boundary or when (re)starting
  always_comb begin
    cnt_d = '0;
    if (en && active_q && !boundary) begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  // A new period always opens high (div >= 2 gives at least one high cycle),
  // so using the old divisor at count 0 is harmless during a switch.
  assign clk_out_d  = en && (cnt_d < (div >> 1));
  assign clk_rise_d = en && (cnt_d == '0);

  // Counter and phase registers; reset forces clk_out low immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      active_q   <= 1'b0;
      clk_out_q  <= 1'b0;
      clk_rise_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      active_q   <= en;
      clk_out_q  <= clk_out_d;
      clk_rise_q <= clk_rise_d;
    end
  end

  assign clk_out  = clk_out_q;
  assign clk_rise = clk_rise_q;

endmodule

// File: rtl/clk_div_switch.sv
// rtl/clk_div_switch.sv - glitch-free programmable clock divider with run gate and divisor handshake
module clk_div_switch
  import clk_div_pkg::*;
#(
  parameter int DIV_W     = 8,
  parameter int RESET_DIV = 2,
  parameter int START_RUN = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_en,
  input  logic             div_valid,
  output logic             div_ready,
  input  logic [DIV_W-1:0] div_value,
  output logic             clk_out,
  output logic             clk_rise,
  output logic             running,
  output logic [DIV_W-1:0] cur_div,
  output logic             switch_done,
  output logic             div_err
);

  // Armed start is RUN with the core still inactive: the first edge after
  // reset opens a period exactly as a run request from IDLE would.
  localparam state_t RESET_STATE = (START_RUN != 0) ? RUN : IDLE;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cur_div_q, cur_div_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             ready_q, ready_d;
  logic             running_q, running_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             accept, legal, boundary, core_en;

  assign accept  = div_valid && ready_q;
  assign legal   = legal_div(32'(div_value));
  assign core_en = (state_d != IDLE);

  clk_div_core #(
    .DIV_W(DIV_W)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (core_en),
    .div     (cur_div_q),
    .clk_out (clk_out),
    .clk_rise(clk_rise),
    .boundary(boundary)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: run/stop and divisor changes only act at period boundaries
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (run_en) state_d = RUN;
      end
      RUN: begin
        if (boundary && !run_en) state_d = IDLE;
        else if (accept && legal) state_d = PEND;
      end
      PEND: begin
        if (boundary) state_d = run_en ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values: divisor load, pending capture, status pulses
  always_comb begin
    cur_div_d = cur_div_q;
    pend_d    = pend_q;
    done_d    = 1'b0;
    err_d     = accept && !legal;
    case (state_q)
      IDLE: begin
        if (accept && legal) begin
          cur_div_d = div_value;
          done_d    = 1'b1;
        end
      end
      RUN: begin
        if (boundary && !run_en) begin
          // Stopping at this boundary: a request arriving now loads directly
          if (accept && legal) begin
            cur_div_d = div_value;
            done_d    = 1'b1;
          end
        end else if (accept && legal) begin
          pend_d = div_value;
        end
      end
      PEND: begin
        if (boundary) begin
          cur_div_d = pend_q;
          done_d    = 1'b1;
        end
      end
      default: ;
    endcase
    ready_d   = (state_d != PEND);
    running_d = core_en;
  end

  // Registered status and divisor state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_div_q <= DIV_W'(RESET_DIV);
      pend_q    <= '0;
      ready_q   <= 1'b1;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cur_div_q <= cur_div_d;
      pend_q    <= pend_d;
      ready_q   <= ready_d;
      running_q <= running_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign div_ready   = ready_q;
  assign running     = running_q;
  assign cur_div     = cur_div_q;
  assign switch_done = done_q;
  assign div_err     = err_q;

endmodule
